serial_adder: RTL and testbench

Bit-serial N-bit adder, the inverse arithmetic partner of the team's combinational subtractor cells. It captures two operands on a start handshake and adds them LSB-first, one bit per clock, through a one-bit full-adder cell and a carry flop. It then presents the sum and carry-out with a one-cycle done pulse. It is used wherever area matters more than latency, for example checking subtractor results by re-adding (diff + b == a).

---
 rtl/serial_adder_pkg.sv | 17 +
 rtl/full_adder_bit.sv | 13 +
 rtl/serial_adder.sv | 124 ++++++++++++
 tb/tb_serial_adder.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder and related serial arithmetic blocks.
package serial_adder_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } state_e;

   localparam int unsigned MAX_WIDTH = 32;

   // Bit-index counter width; never below one bit so the counter stays declarable.
   function automatic int unsigned cnt_width(input int unsigned width);
      return (width <= 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/full_adder_bit.sv
// One-bit combinational full adder cell.
module full_adder_bit (
   input  logic i_a,
   input  logic i_b,
   input  logic i_cin,
   output logic o_s,
   output logic o_cout
);

   assign o_s    = i_a ^ i_b ^ i_cin;
   assign o_cout = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, one bit per clock.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output o_ovf.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic             o_ready,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_sum,
   output logic             o_cout
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             o_ovf
`endif
);

   localparam int unsigned CW = cnt_width(WIDTH);

   state_e           r_state;
   state_e           w_state_next;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-2:0] r_res;
   logic             r_carry;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;
`ifdef SERIAL_ADDER_OVF_EN
   logic             r_ovf;
`endif

   logic             w_accept;
   logic             w_run;
   logic             w_last;
   logic             w_fa_s;
   logic             w_fa_cout;
   logic [WIDTH-1:0] w_res_next;

   assign w_accept   = i_start & o_ready;
   assign w_run      = (r_state == StRun);
   assign w_last     = w_run && (r_cnt == CW'(WIDTH - 1));
   assign w_res_next = {w_fa_s, r_res};

   full_adder_bit u_fa (
      .i_a    (r_a[0]),
      .i_b    (r_b[0]),
      .i_cin  (r_carry),
      .o_s    (w_fa_s),
      .o_cout (w_fa_cout)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle:  if (w_accept) w_state_next = StRun;
         StRun:   if (w_last) w_state_next = StDone;
         StDone:  w_state_next = w_accept ? StRun : StIdle;
         default: w_state_next = StIdle;
      endcase
   end

   always_comb begin
      o_ready = (r_state == StIdle) || (r_state == StDone);
      o_busy  = (r_state == StRun);
      o_done  = (r_state == StDone);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_a     <= '0;
         r_b     <= '0;
         r_res   <= '0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         r_ovf   <= 1'b0;
`endif
      end else if (w_accept) begin
         r_a     <= i_a;
         r_b     <= i_b;
         r_carry <= 1'b0;
         r_cnt   <= '0;
      end else if (w_run) begin
         r_a     <= r_a >> 1;
         r_b     <= r_b >> 1;
         r_carry <= w_fa_cout;
         r_res   <= w_res_next[WIDTH-1:1];
         if (w_last) begin
            r_sum  <= w_res_next;
            r_cout <= w_fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
            // On the MSB step r_carry is the carry into the MSB.
            r_ovf  <= r_carry ^ w_fa_cout;
`endif
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

   assign o_sum  = r_sum;
   assign o_cout = r_cout;
`ifdef SERIAL_ADDER_OVF_EN
   assign o_ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8 and WIDTH=13 against plain a+b arithmetic.
// With SERIAL_ADDER_OVF_EN defined, the signed-overflow output is checked as well.
module tb_serial_adder;

   logic        clk;
   logic        rst;
   logic        start8;
   logic        start13;
   logic [31:0] a_in;
   logic [31:0] b_in;

   logic        ready8, busy8, done8, cout8;
   logic [7:0]  sum8;
   logic        ready13, busy13, done13, cout13;
   logic [12:0] sum13;
`ifdef SERIAL_ADDER_OVF_EN
   logic        ovf8, ovf13;
`endif

   int n_assert = 0;
   int n_fail   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   serial_adder #(.WIDTH(8)) u8 (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_start (start8),
      .i_a     (a_in[7:0]),
      .i_b     (b_in[7:0]),
      .o_ready (ready8),
      .o_busy  (busy8),
      .o_done  (done8),
      .o_sum   (sum8),
      .o_cout  (cout8)
`ifdef SERIAL_ADDER_OVF_EN
      ,
      .o_ovf   (ovf8)
`endif
   );

   serial_adder #(.WIDTH(13)) u13 (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_start (start13),
      .i_a     (a_in[12:0]),
      .i_b     (b_in[12:0]),
      .o_ready (ready13),
      .o_busy  (busy13),
      .o_done  (done13),
      .o_sum   (sum13),
      .o_cout  (cout13)
`ifdef SERIAL_ADDER_OVF_EN
      ,
      .o_ovf   (ovf13)
`endif
   );

   function automatic logic f_done(input int w);
      return (w == 8) ? done8 : done13;
   endfunction

   function automatic logic f_busy(input int w);
      return (w == 8) ? busy8 : busy13;
   endfunction

   function automatic logic f_ready(input int w);
      return (w == 8) ? ready8 : ready13;
   endfunction

   function automatic logic f_cout(input int w);
      return (w == 8) ? cout8 : cout13;
   endfunction

   function automatic logic [63:0] f_sum(input int w);
      return (w == 8) ? {56'd0, sum8} : {51'd0, sum13};
   endfunction

`ifdef SERIAL_ADDER_OVF_EN
   function automatic logic f_ovf(input int w);
      return (w == 8) ? ovf8 : ovf13;
   endfunction
`endif

   function automatic logic [63:0] mask(input int w);
      return (64'd1 << w) - 64'd1;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Issue one start pulse and wait (bounded) for done; caller checks the results.
   task automatic run_op(input int w, input logic [63:0] a, input logic [63:0] b,
                         output int nb, output logic [63:0] mid_sum);
      int t;
      a_in = a[31:0];
      b_in = b[31:0];
      if (w == 8) start8 = 1'b1;
      else start13 = 1'b1;
      @(negedge clk);
      start8  = 1'b0;
      start13 = 1'b0;
      mid_sum = f_sum(w);
      nb = 0;
      t  = 0;
      while (!f_done(w) && t < 64) begin
         if (f_busy(w)) nb++;
         @(negedge clk);
         t++;
      end
   endtask

   // Full result check of one operation against unsigned arithmetic.
   task automatic op_check(input string tag, input int w, input logic [63:0] a,
                           input logic [63:0] b);
      int          nb;
      logic [63:0] mid;
      logic [63:0] full;
      logic [63:0] s;
      run_op(w, a, b, nb, mid);
      full = a + b;
      s    = f_sum(w);
      chk({tag, "_done"}, {63'd0, f_done(w)}, 64'd1);
      chk({tag, "_sum"}, s, full & mask(w));
      chk({tag, "_cout"}, {63'd0, f_cout(w)}, (full >> w) & 64'd1);
      chk({tag, "_sub"}, (s - b) & mask(w), a);
      chk({tag, "_lat"}, nb, w);
`ifdef SERIAL_ADDER_OVF_EN
      chk({tag, "_ovf"}, {63'd0, f_ovf(w)},
          {63'd0, (a[w-1] == b[w-1]) && (s[w-1] != a[w-1])});
`endif
   endtask

   initial begin
      int          nb;
      int          t;
      int          pulses;
      logic [63:0] mid;
      logic [63:0] ra;
      logic [63:0] rb;

      rst     = 1'b1;
      start8  = 1'b0;
      start13 = 1'b0;
      a_in    = '0;
      b_in    = '0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      chk("rst_ready", {63'd0, ready8}, 64'd1);
      chk("rst_busy", {63'd0, busy8}, 64'd0);
      chk("rst_done", {63'd0, done8}, 64'd0);
      chk("rst_sum", {56'd0, sum8}, 64'd0);
      chk("rst_cout", {63'd0, cout8}, 64'd0);

      // Basic addition, latency and done pulse width
      op_check("t1", 8, 64'd3, 64'd5);
      chk("t1_sum8", {56'd0, sum8}, 64'h08);
      @(negedge clk);
      chk("t1_done_pulse", {63'd0, done8}, 64'd0);
      chk("t1_idle_ready", {63'd0, ready8}, 64'd1);
      chk("t1_sum_hold", {56'd0, sum8}, 64'h08);

      op_check("t2a", 8, 64'hFF, 64'h01);
      run_op(8, 64'hFF, 64'hFF, nb, mid);
      chk("t2b_mid_hold", mid, 64'h00);
      chk("t2b_sum", {56'd0, sum8}, 64'hFE);
      chk("t2b_cout", {63'd0, cout8}, 64'd1);
      @(negedge clk);

      // Start held high, operands changed mid-RUN: back-to-back accept in DONE
      a_in   = 32'd10;
      b_in   = 32'd20;
      start8 = 1'b1;
      @(negedge clk);
      a_in = 32'd7;
      b_in = 32'd9;
      t = 0;
      while (!done8 && t < 64) begin
         @(negedge clk);
         t++;
      end
      chk("t3_first_done", {63'd0, done8}, 64'd1);
      chk("t3_first_lat", t, 8);
      chk("t3_first_sum", {56'd0, sum8}, 64'd30);
      @(negedge clk);
      chk("t3_b2b_busy", {63'd0, busy8}, 64'd1);
      start8 = 1'b0;
      a_in   = 32'h55;
      b_in   = 32'h11;
      t = 1;
      while (!done8 && t < 64) begin
         @(negedge clk);
         t++;
      end
      chk("t3_second_done", {63'd0, done8}, 64'd1);
      chk("t3_interval", t, 9);
      chk("t3_second_sum", {56'd0, sum8}, 64'd16);
      @(negedge clk);
      chk("t3_no_third", {63'd0, busy8 | done8}, 64'd0);

      // Reset during RUN aborts the operation
      a_in   = 32'd100;
      b_in   = 32'd100;
      start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      repeat (3) @(negedge clk);
      chk("t4_busy_before", {63'd0, busy8}, 64'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("t4_busy", {63'd0, busy8}, 64'd0);
      chk("t4_done", {63'd0, done8}, 64'd0);
      chk("t4_sum", {56'd0, sum8}, 64'd0);
      chk("t4_cout", {63'd0, cout8}, 64'd0);
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         if (done8 || busy8) pulses++;
         @(negedge clk);
      end
      chk("t4_no_done", pulses, 0);
      op_check("t4_fresh", 8, 64'd1, 64'd2);

`ifdef SERIAL_ADDER_OVF_EN
      op_check("t6a", 8, 64'h7F, 64'h01);
      chk("t6a_ovf", {63'd0, ovf8}, 64'd1);
      op_check("t6b", 8, 64'h80, 64'h80);
      chk("t6b_ovf", {63'd0, ovf8}, 64'd1);
      op_check("t6c", 8, 64'h05, 64'hFB);
      chk("t6c_ovf", {63'd0, ovf8}, 64'd0);
`endif

      // Random operands at both widths
      for (int i = 0; i < 1000; i++) begin
         ra = {32'd0, $urandom} & mask(8);
         rb = {32'd0, $urandom} & mask(8);
         op_check("rnd8", 8, ra, rb);
      end
      @(negedge clk);
      chk("w13_ready", {63'd0, f_ready(13)}, 64'd1);
      op_check("w13_max", 13, 64'h1FFF, 64'h1FFF);
      for (int i = 0; i < 1000; i++) begin
         ra = {32'd0, $urandom} & mask(13);
         rb = {32'd0, $urandom} & mask(13);
         op_check("rnd13", 13, ra, rb);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
